// File: rtl/udp_vlg_rx_if.sv
// UDP receive parser interface.
// Groups the IPv4 payload input stream, the parsed-header meta bus and the
// UDP payload output stream.
//   slave  : parser side (consumes in_*, drives meta_* and out_*)
//   master : upstream/downstream side (drives in_*, observes meta_* and out_*)
interface udp_vlg_rx_if;
   // IPv4 payload stream
   logic        in_val;
   logic        in_sof;
   logic        in_eof;
   logic        in_err;
   logic [7:0]  in_dat;
   logic [31:0] in_src_ip;
   logic [31:0] in_dst_ip;
   logic [15:0] in_pld_len;
   // Parsed header
   logic        meta_val;
   logic [15:0] meta_src_port;
   logic [15:0] meta_dst_port;
   logic [15:0] meta_length;
   logic [31:0] meta_src_ip;
   logic [31:0] meta_dst_ip;
   // UDP payload stream
   logic        out_val;
   logic        out_sof;
   logic        out_eof;
   logic        out_err;
   logic [7:0]  out_dat;

   modport slave (
      input  in_val, in_sof, in_eof, in_err, in_dat, in_src_ip, in_dst_ip, in_pld_len,
      output meta_val, meta_src_port, meta_dst_port, meta_length, meta_src_ip, meta_dst_ip,
      output out_val, out_sof, out_eof, out_err, out_dat
   );

   modport master (
      output in_val, in_sof, in_eof, in_err, in_dat, in_src_ip, in_dst_ip, in_pld_len,
      input  meta_val, meta_src_port, meta_dst_port, meta_length, meta_src_ip, meta_dst_ip,
      input  out_val, out_sof, out_eof, out_err, out_dat
   );
endinterface

// File: rtl/udp_vlg_rx.sv
// UDP receive parser.
// Strips the 8-byte UDP header from the IPv4 payload stream, publishes the
// header fields plus IPv4 addresses on meta_* (meta_val pulses once per
// accepted datagram), and forwards the payload trimmed to the UDP length with
// 1-cycle latency. Malformed, truncated or restarted datagrams are flagged
// with out_err on the closing out_eof beat.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : udp_vlg_rx_if.slave (in_* stream, meta_* bus, out_* stream)
// Build option: define UDP_VLG_RX_CHKSUM_EN to verify the UDP checksum
// (pseudo-header + header + payload); a bad sum sets out_err on out_eof and
// suppresses meta_val for header-only datagrams. A zero checksum field means
// "not computed" and always passes.
module udp_vlg_rx (
   input  logic          clk,
   input  logic          rst,
   udp_vlg_rx_if.slave   bus
);

   typedef enum logic [1:0] {StIdle, StHdr, StPld, StDiscard} state_e;

   state_e      state_q, state_d;
   logic [15:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
   logic [15:0] src_port_q, src_port_d;
   logic [15:0] dst_port_q, dst_port_d;
   logic [15:0] len_q, len_d;
   logic        frame_open_q, frame_open_d;
   logic        last_byte;
   logic        csum_bad;

   logic        meta_val_q, meta_val_d;
   logic [15:0] meta_src_port_q, meta_src_port_d;
   logic [15:0] meta_dst_port_q, meta_dst_port_d;
   logic [15:0] meta_length_q, meta_length_d;
   logic [31:0] meta_src_ip_q, meta_src_ip_d;
   logic [31:0] meta_dst_ip_q, meta_dst_ip_d;

   logic        out_val_q, out_val_d;
   logic        out_sof_q, out_sof_d;
   logic        out_eof_q, out_eof_d;
   logic        out_err_q, out_err_d;
   logic [7:0]  out_dat_q, out_dat_d;

`ifdef UDP_VLG_RX_CHKSUM_EN
   logic [15:0] csum_q, csum_d, csum_word, csum_fin, chk_q, chk_d, chk_now;
   logic [7:0]  hi_q, hi_d;

   function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   // Odd byte index completes a 16-bit word; an even index as the final byte
   // is a trailing odd byte padded with 0x00.
   assign csum_word = byte_cnt_q[0] ? {hi_q, bus.in_dat} : {bus.in_dat, 8'h00};
   assign csum_fin  = ones_add(csum_q, csum_word);
   assign chk_now   = (state_q == StHdr) ? {hi_q, bus.in_dat} : chk_q;
   assign csum_bad  = (chk_now != 16'h0000) && (csum_fin != 16'hFFFF);

   always_comb begin
      csum_d = csum_q;
      hi_d   = hi_q;
      chk_d  = chk_q;
      if (bus.in_val && bus.in_sof) begin
         // Seed with the address part of the pseudo-header plus protocol 17.
         csum_d = ones_add(ones_add(ones_add(ones_add(bus.in_src_ip[31:16], bus.in_src_ip[15:0]),
                  bus.in_dst_ip[31:16]), bus.in_dst_ip[15:0]), 16'h0011);
         hi_d   = bus.in_dat;
      end else if (bus.in_val && (state_q == StHdr || state_q == StPld)) begin
         if (!byte_cnt_q[0]) begin
            hi_d = bus.in_dat;
         end else begin
            csum_d = ones_add(csum_q, {hi_q, bus.in_dat});
            // UDP length also appears in the pseudo-header.
            if (state_q == StHdr && byte_cnt_q[2:0] == 3'd5) begin
               csum_d = ones_add(csum_d, {hi_q, bus.in_dat});
            end
            if (state_q == StHdr && byte_cnt_q[2:0] == 3'd7) begin
               chk_d = {hi_q, bus.in_dat};
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum_q <= '0;
         hi_q   <= '0;
         chk_q  <= '0;
      end else begin
         csum_q <= csum_d;
         hi_q   <= hi_d;
         chk_q  <= chk_d;
      end
   end
`else
   assign csum_bad = 1'b0;
`endif

   assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
   assign last_byte    = (byte_cnt_q == len_q - 16'd1);

   always_comb begin
      state_d         = state_q;
      byte_cnt_d      = byte_cnt_q;
      src_port_d      = src_port_q;
      dst_port_d      = dst_port_q;
      len_d           = len_q;
      frame_open_d    = frame_open_q;
      meta_val_d      = 1'b0;
      meta_src_port_d = meta_src_port_q;
      meta_dst_port_d = meta_dst_port_q;
      meta_length_d   = meta_length_q;
      meta_src_ip_d   = meta_src_ip_q;
      meta_dst_ip_d   = meta_dst_ip_q;
      out_val_d       = 1'b0;
      out_sof_d       = 1'b0;
      out_eof_d       = 1'b0;
      out_err_d       = 1'b0;
      out_dat_d       = 8'h00;

      if (bus.in_val) begin
         if (bus.in_sof) begin
            // New datagram; an open output frame is closed with an error beat.
            if (frame_open_q) begin
               out_val_d = 1'b1;
               out_eof_d = 1'b1;
               out_err_d = 1'b1;
            end
            frame_open_d     = 1'b0;
            src_port_d[15:8] = bus.in_dat;
            byte_cnt_d       = 16'd1;
            state_d          = bus.in_eof ? StIdle : StHdr;
         end else begin
            unique case (state_q)
               StIdle: ;
               StHdr: begin
                  byte_cnt_d = byte_cnt_inc;
                  case (byte_cnt_q[2:0])
                     3'd1:    src_port_d[7:0]  = bus.in_dat;
                     3'd2:    dst_port_d[15:8] = bus.in_dat;
                     3'd3:    dst_port_d[7:0]  = bus.in_dat;
                     3'd4:    len_d[15:8]      = bus.in_dat;
                     3'd5:    len_d[7:0]       = bus.in_dat;
                     default: ;
                  endcase
                  if (byte_cnt_q[2:0] == 3'd7) begin
                     meta_src_port_d = src_port_q;
                     meta_dst_port_d = dst_port_q;
                     meta_length_d   = len_q;
                     meta_src_ip_d   = bus.in_src_ip;
                     meta_dst_ip_d   = bus.in_dst_ip;
                     if (len_q == 16'd8) begin
                        meta_val_d = !csum_bad;
                        state_d    = bus.in_eof ? StIdle : StDiscard;
                     end else if (bus.in_eof || len_q < 16'd8 || len_q > bus.in_pld_len) begin
                        state_d = bus.in_eof ? StIdle : StDiscard;
                     end else begin
                        meta_val_d = 1'b1;
                        state_d    = StPld;
                     end
                  end else if (bus.in_eof) begin
                     state_d = StIdle;
                  end
               end
               StPld: begin
                  byte_cnt_d   = byte_cnt_inc;
                  out_val_d    = 1'b1;
                  out_dat_d    = bus.in_dat;
                  out_sof_d    = (byte_cnt_q == 16'd8);
                  out_eof_d    = last_byte || bus.in_eof;
                  out_err_d    = (bus.in_eof && (!last_byte || bus.in_err)) ||
                                 (last_byte && csum_bad);
                  frame_open_d = !(last_byte || bus.in_eof);
                  if (bus.in_eof)     state_d = StIdle;
                  else if (last_byte) state_d = StDiscard;
               end
               StDiscard: begin
                  if (bus.in_eof) state_d = StIdle;
               end
               default: state_d = StIdle;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= StIdle;
         byte_cnt_q      <= '0;
         src_port_q      <= '0;
         dst_port_q      <= '0;
         len_q           <= '0;
         frame_open_q    <= 1'b0;
         meta_val_q      <= 1'b0;
         meta_src_port_q <= '0;
         meta_dst_port_q <= '0;
         meta_length_q   <= '0;
         meta_src_ip_q   <= '0;
         meta_dst_ip_q   <= '0;
         out_val_q       <= 1'b0;
         out_sof_q       <= 1'b0;
         out_eof_q       <= 1'b0;
         out_err_q       <= 1'b0;
         out_dat_q       <= '0;
      end else begin
         state_q         <= state_d;
         byte_cnt_q      <= byte_cnt_d;
         src_port_q      <= src_port_d;
         dst_port_q      <= dst_port_d;
         len_q           <= len_d;
         frame_open_q    <= frame_open_d;
         meta_val_q      <= meta_val_d;
         meta_src_port_q <= meta_src_port_d;
         meta_dst_port_q <= meta_dst_port_d;
         meta_length_q   <= meta_length_d;
         meta_src_ip_q   <= meta_src_ip_d;
         meta_dst_ip_q   <= meta_dst_ip_d;
         out_val_q       <= out_val_d;
         out_sof_q       <= out_sof_d;
         out_eof_q       <= out_eof_d;
         out_err_q       <= out_err_d;
         out_dat_q       <= out_dat_d;
      end
   end

   assign bus.meta_val      = meta_val_q;
   assign bus.meta_src_port = meta_src_port_q;
   assign bus.meta_dst_port = meta_dst_port_q;
   assign bus.meta_length   = meta_length_q;
   assign bus.meta_src_ip   = meta_src_ip_q;
   assign bus.meta_dst_ip   = meta_dst_ip_q;
   assign bus.out_val       = out_val_q;
   assign bus.out_sof       = out_sof_q;
   assign bus.out_eof       = out_eof_q;
   assign bus.out_err       = out_err_q;
   assign bus.out_dat       = out_dat_q;

endmodule

// File: tb/tb_udp_vlg_rx.sv
// Directed bench for udp_vlg_rx: drives hand-built datagrams and compares the
// collected output beats and meta fields against hand-computed values.
module tb_udp_vlg_rx;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   meta_cnt = 0;
   bit   done = 1'b0;
   logic [10:0] beats[$];  // {sof, eof, err, dat}

   udp_vlg_rx_if bus ();

   udp_vlg_rx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_val) beats.push_back({bus.out_sof, bus.out_eof, bus.out_err, bus.out_dat});
         if (bus.meta_val) meta_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      if (!done) begin
         errors++;
         $error("FAIL timeout: stimulus did not complete");
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   function automatic bq_t hdr(input logic [15:0] sp, input logic [15:0] dp,
                               input logic [15:0] ln, input logic [15:0] ck);
      bq_t q;
      q.push_back(sp[15:8]); q.push_back(sp[7:0]);
      q.push_back(dp[15:8]); q.push_back(dp[7:0]);
      q.push_back(ln[15:8]); q.push_back(ln[7:0]);
      q.push_back(ck[15:8]); q.push_back(ck[7:0]);
      return q;
   endfunction

   task automatic idle_in();
      bus.in_val = 1'b0;
      bus.in_sof = 1'b0;
      bus.in_eof = 1'b0;
      bus.in_err = 1'b0;
      bus.in_dat = 8'h00;
   endtask

   task automatic clear();
      beats.delete();
      meta_cnt = 0;
   endtask

   // sof2: second in_sof index (-1 none); gap_at: idle cycle before that byte;
   // probe: check 1-cycle latency after that byte.
   task automatic send(input bq_t q, input int sof2, input int eof_at, input bit err,
                       input int gap_at, input int probe);
      for (int i = 0; i < q.size(); i++) begin
         if (i == gap_at) begin
            @(negedge clk);
            idle_in();
         end
         @(negedge clk);
         bus.in_val = 1'b1;
         bus.in_sof = (i == 0) || (i == sof2);
         bus.in_eof = (i == eof_at);
         bus.in_err = err && (i == eof_at);
         bus.in_dat = q[i];
         if (i == probe) begin
            @(posedge clk);
            #1;
            chk("latency_val", bus.out_val, 1'b1);
            chk("latency_dat", bus.out_dat, q[i]);
         end
      end
      @(negedge clk);
      idle_in();
      repeat (4) @(negedge clk);
   endtask

   initial begin
      bq_t q;
      idle_in();
      bus.in_src_ip  = 32'h0A000001;
      bus.in_dst_ip  = 32'h0A000002;
      bus.in_pld_len = 16'd0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_out_val", bus.out_val, 1'b0);
      chk("rst_meta_val", bus.meta_val, 1'b0);
      chk("rst_meta_len", bus.meta_length, 16'h0000);
      chk("rst_meta_sip", bus.meta_src_ip, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic datagram 10.0.0.1:1234 -> 10.0.0.2:5678, checksum 0x3336 is correct
      clear();
      bus.in_pld_len = 16'd12;
      q = hdr(16'd1234, 16'd5678, 16'd12, 16'h3336);
      q.push_back(8'hDE); q.push_back(8'hAD); q.push_back(8'hBE); q.push_back(8'hEF);
      send(q, -1, 11, 1'b0, -1, 8);
      chk("t1_meta_cnt", meta_cnt, 1);
      chk("t1_src_port", bus.meta_src_port, 16'h04D2);
      chk("t1_dst_port", bus.meta_dst_port, 16'h162E);
      chk("t1_length", bus.meta_length, 16'h000C);
      chk("t1_src_ip", bus.meta_src_ip, 32'h0A000001);
      chk("t1_dst_ip", bus.meta_dst_ip, 32'h0A000002);
      chk("t1_nbeats", beats.size(), 4);
      if (beats.size() == 4) begin
         chk("t1_beat0", beats[0], {3'b100, 8'hDE});
         chk("t1_beat1", beats[1], {3'b000, 8'hAD});
         chk("t1_beat2", beats[2], {3'b000, 8'hBE});
         chk("t1_beat3", beats[3], {3'b010, 8'hEF});
      end

      // Length 10 with 4 pad bytes, gap inside payload
      clear();
      bus.in_pld_len = 16'd14;
      q = hdr(16'h0035, 16'h1000, 16'd10, 16'h0000);
      q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
      q.push_back(8'h44); q.push_back(8'h55); q.push_back(8'h66);
      send(q, -1, 13, 1'b0, 9, -1);
      chk("t2_meta_cnt", meta_cnt, 1);
      chk("t2_nbeats", beats.size(), 2);
      if (beats.size() == 2) begin
         chk("t2_beat0", beats[0], {3'b100, 8'h11});
         chk("t2_beat1", beats[1], {3'b010, 8'h22});
      end

      // Runt: eof after 5 bytes
      clear();
      q = hdr(16'h0001, 16'h0002, 16'd12, 16'h0000);
      q = q[0:4];
      send(q, -1, 4, 1'b0, -1, -1);
      chk("t3_meta_cnt", meta_cnt, 0);
      chk("t3_nbeats", beats.size(), 0);

      // Truncated: length 20 but eof at payload byte 6
      clear();
      bus.in_pld_len = 16'd20;
      q = hdr(16'h0100, 16'h0200, 16'd20, 16'h0000);
      for (int i = 0; i < 6; i++) q.push_back(8'(8'hA0 + i));
      send(q, -1, 13, 1'b0, -1, -1);
      chk("t4_meta_cnt", meta_cnt, 1);
      chk("t4_nbeats", beats.size(), 6);
      if (beats.size() == 6) begin
         chk("t4_beat5", beats[5], {3'b011, 8'hA5});
      end

      // Restart at payload byte 3 of a length-16 datagram
      clear();
      bus.in_pld_len = 16'd16;
      q = hdr(16'h0300, 16'h0400, 16'd16, 16'h0000);
      q.push_back(8'h51); q.push_back(8'h52);
      begin
         bq_t b;
         b = hdr(16'h0500, 16'h0600, 16'd10, 16'h0000);
         b.push_back(8'hAA); b.push_back(8'hBB);
         foreach (b[i]) q.push_back(b[i]);
      end
      send(q, 10, 19, 1'b0, -1, -1);
      chk("t5_meta_cnt", meta_cnt, 2);
      chk("t5_nbeats", beats.size(), 5);
      if (beats.size() == 5) begin
         chk("t5_beat0", beats[0], {3'b100, 8'h51});
         chk("t5_beat1", beats[1], {3'b000, 8'h52});
         chk("t5_abort", beats[2], {3'b011, 8'h00});
         chk("t5_beat3", beats[3], {3'b100, 8'hAA});
         chk("t5_beat4", beats[4], {3'b010, 8'hBB});
      end
      chk("t5_dst_port", bus.meta_dst_port, 16'h0600);

      // Upstream error on final byte
      clear();
      bus.in_pld_len = 16'd10;
      q = hdr(16'h0700, 16'h0800, 16'd10, 16'h0000);
      q.push_back(8'h01); q.push_back(8'h02);
      send(q, -1, 9, 1'b1, -1, -1);
      chk("t6_nbeats", beats.size(), 2);
      if (beats.size() == 2) begin
         chk("t6_beat1", beats[1], {3'b011, 8'h02});
      end

      // Length < 8 and length > pld_len: dropped silently
      clear();
      bus.in_pld_len = 16'd12;
      q = hdr(16'h0900, 16'h0A00, 16'd6, 16'h0000);
      q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03); q.push_back(8'h04);
      send(q, -1, 11, 1'b0, -1, -1);
      q = hdr(16'h0900, 16'h0A00, 16'd30, 16'h0000);
      q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03); q.push_back(8'h04);
      send(q, -1, 11, 1'b0, -1, -1);
      chk("t7_meta_cnt", meta_cnt, 0);
      chk("t7_nbeats", beats.size(), 0);

      // Header-only datagram
      clear();
      bus.in_pld_len = 16'd8;
      q = hdr(16'h0B00, 16'h0C00, 16'd8, 16'h0000);
      send(q, -1, 7, 1'b0, -1, -1);
      chk("t8_meta_cnt", meta_cnt, 1);
      chk("t8_nbeats", beats.size(), 0);
      chk("t8_length", bus.meta_length, 16'h0008);

`ifdef UDP_VLG_RX_CHKSUM_EN
      // Payload bit flip against checksum 0x3336
      clear();
      bus.in_pld_len = 16'd12;
      q = hdr(16'd1234, 16'd5678, 16'd12, 16'h3336);
      q.push_back(8'hDF); q.push_back(8'hAD); q.push_back(8'hBE); q.push_back(8'hEF);
      send(q, -1, 11, 1'b0, -1, -1);
      chk("c1_nbeats", beats.size(), 4);
      if (beats.size() == 4) begin
         chk("c1_bad_sum", beats[3], {3'b011, 8'hEF});
      end
      // Zero checksum field: not checked
      clear();
      q = hdr(16'd1234, 16'd5678, 16'd12, 16'h0000);
      q.push_back(8'hDF); q.push_back(8'hAD); q.push_back(8'hBE); q.push_back(8'hEF);
      send(q, -1, 11, 1'b0, -1, -1);
      chk("c2_nbeats", beats.size(), 4);
      if (beats.size() == 4) begin
         chk("c2_zero_sum", beats[3], {3'b010, 8'hEF});
      end
`endif

      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
